// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing_pkg
//  Description : Shared constants, types and helper functions for the
//                480x272 TFT-LCD raster timing generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_timing_pkg;

  // Width of every position counter and coordinate output.
  localparam int CNT_W = 10;

  // Largest line/frame total the CNT_W-bit counters can represent.
  localparam int MAX_TOTAL = 1 << CNT_W;

  // Default panel timing (480x272): pixels per line / lines per frame.
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Registered output bundle; every field describes the same pixel.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    cnt_t h_count;
    cnt_t v_count;
    logic line_start;
    logic frame_start;
    cnt_t pix_x;
    cnt_t pix_y;
  } timing_t;

  // Idle values: syncs inactive (high), everything else zero.
  localparam timing_t TIMING_RESET = '{
    hsync       : 1'b1,
    vsync       : 1'b1,
    de          : 1'b0,
    h_count     : '0,
    v_count     : '0,
    line_start  : 1'b0,
    frame_start : 1'b0,
    pix_x       : '0,
    pix_y       : '0
  };

  // Total length of one axis: sync + back porch + active + front porch.
  function automatic int calc_axis_total(input int sync, input int bp,
                                         input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  // Pixels per line including blanking.
  function automatic int calc_h_total(input int h_sync, input int h_bp,
                                      input int h_active, input int h_fp);
    return calc_axis_total(h_sync, h_bp, h_active, h_fp);
  endfunction

  // Lines per frame including blanking.
  function automatic int calc_v_total(input int v_sync, input int v_bp,
                                      input int v_active, input int v_fp);
    return calc_axis_total(v_sync, v_bp, v_active, v_fp);
  endfunction

endpackage : lcd_timing_pkg
`default_nettype wire

// File: rtl/lcd_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_axis_counter
//  Description : Generic wrapping position counter for one raster axis with
//                region decode (sync, back porch, active, front porch).
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int SYNC   = 1,
  parameter int BP     = 0,
  parameter int ACTIVE = 1,
  parameter int FP     = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] pos_o,
  output logic             sync_act_o,
  output logic             de_o,
  output logic             last_o
);

  localparam int TOTAL = calc_axis_total(SYNC, BP, ACTIVE, FP);

  // One extra bit so region bounds equal to MAX_TOTAL do not alias to zero.
  localparam int EXT_W = CNT_W + 1;

  localparam logic [EXT_W-1:0] C_SYNC_END = EXT_W'(SYNC);
  localparam logic [EXT_W-1:0] C_ACT_BEG  = EXT_W'(SYNC + BP);
  localparam logic [EXT_W-1:0] C_ACT_END  = EXT_W'(SYNC + BP + ACTIVE);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] pos_d;
  logic [EXT_W-1:0] w_pos_ext;
  logic             w_last;

  assign w_pos_ext = {1'b0, pos_q};
  assign w_last    = (pos_q == C_LAST);

  // Advance on each step, wrapping from the last position back to zero.
  always_comb begin
    pos_d = pos_q;
    if (step_i) begin
      if (w_last) begin
        pos_d = '0;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // Position register; reset wins over step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o      = pos_q;
  assign sync_act_o = (w_pos_ext < C_SYNC_END);
  assign de_o       = (w_pos_ext >= C_ACT_BEG) && (w_pos_ext < C_ACT_END);
  assign last_o     = w_last;

endmodule : lcd_axis_counter
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timing_gen
//  Description : Raster timing generator (Hsync, Vsync, DE, counters and
//                line/frame markers) for a 480x272 TFT-LCD, advanced by a
//                pixel-clock enable on the system clock.
//                Optional macro LCD_TIMING_PIXCOORD_EN enables the active-area
//                coordinate outputs PIX_X/PIX_Y (tied to zero otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PIX_CE,
  output logic             Hsync,
  output logic             Vsync,
  output logic             DE,
  output logic [CNT_W-1:0] H_COUNT,
  output logic [CNT_W-1:0] V_COUNT,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic [CNT_W-1:0] PIX_X,
  output logic [CNT_W-1:0] PIX_Y
);

  localparam int H_TOTAL = calc_h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = calc_v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  // Reject timings whose totals do not fit the position counters.
  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("lcd_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("lcd_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
  end

  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;
  logic             h_sync_act;
  logic             v_sync_act;
  logic             h_de;
  logic             v_de;
  logic             h_last;
  logic             v_last;
  logic             v_step;

  timing_t out_q;
  timing_t out_d;

  // The line counter steps on the pixel that closes the current line, so
  // the horizontal wrap and vertical increment share one edge.
  assign v_step = h_last & PIX_CE;

  lcd_axis_counter #(
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP)
  ) u_h_axis (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .step_i     (PIX_CE),
    .pos_o      (h_pos),
    .sync_act_o (h_sync_act),
    .de_o       (h_de),
    .last_o     (h_last)
  );

  lcd_axis_counter #(
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP)
  ) u_v_axis (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .step_i     (v_step),
    .pos_o      (v_pos),
    .sync_act_o (v_sync_act),
    .de_o       (v_de),
    .last_o     (v_last)
  );

`ifdef LCD_TIMING_PIXCOORD_EN
  localparam logic [CNT_W-1:0] C_X_OFS = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] C_Y_OFS = CNT_W'(V_SYNC + V_BP);
`endif

  // Capture the decoded pixel on each enable; markers only live one cycle.
  always_comb begin
    out_d             = out_q;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (PIX_CE) begin
      out_d.hsync       = ~h_sync_act;
      out_d.vsync       = ~v_sync_act;
      out_d.de          = h_de & v_de;
      out_d.h_count     = h_pos;
      out_d.v_count     = v_pos;
      out_d.line_start  = (h_pos == '0);
      out_d.frame_start = (h_pos == '0) && (v_pos == '0);
`ifdef LCD_TIMING_PIXCOORD_EN
      if (h_de & v_de) begin
        out_d.pix_x = h_pos - C_X_OFS;
        out_d.pix_y = v_pos - C_Y_OFS;
      end else begin
        out_d.pix_x = '0;
        out_d.pix_y = '0;
      end
`else
      out_d.pix_x = '0;
      out_d.pix_y = '0;
`endif
    end
  end

  // Output register bank; reset has priority over the pixel enable.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q <= TIMING_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  // The frame wrap is already implied by the vertical counter itself.
  logic w_unused;
  assign w_unused = v_last;

  assign Hsync       = out_q.hsync;
  assign Vsync       = out_q.vsync;
  assign DE          = out_q.de;
  assign H_COUNT     = out_q.h_count;
  assign V_COUNT     = out_q.v_count;
  assign LINE_START  = out_q.line_start;
  assign FRAME_START = out_q.frame_start;
  assign PIX_X       = out_q.pix_x;
  assign PIX_Y       = out_q.pix_y;

endmodule : lcd_timing_gen
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_timing_gen
//  Description : Scoreboard bench for lcd_timing_gen: a default 480x272
//                instance plus a tiny-raster instance sharing one stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       ls;
    logic       fs;
    logic [9:0] px;
    logic [9:0] py;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic ce;
    exp_t d;
    exp_t s;
  } sb_ent_t;

  localparam exp_t EXP_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_hc, d_vc, d_px, d_py;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_hc, s_vc, s_px, s_py;

  lcd_timing_gen u_dut (
    .CLK         (clk),
    .RESET       (rst),
    .PIX_CE      (ce),
    .Hsync       (d_hs),
    .Vsync       (d_vs),
    .DE          (d_de),
    .H_COUNT     (d_hc),
    .V_COUNT     (d_vc),
    .LINE_START  (d_ls),
    .FRAME_START (d_fs),
    .PIX_X       (d_px),
    .PIX_Y       (d_py)
  );

  // 15 x 8 raster: sync 3/2, back porch 2/1, active 8/4, front porch 2/1.
  lcd_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) u_small (
    .CLK         (clk),
    .RESET       (rst),
    .PIX_CE      (ce),
    .Hsync       (s_hs),
    .Vsync       (s_vs),
    .DE          (s_de),
    .H_COUNT     (s_hc),
    .V_COUNT     (s_vc),
    .LINE_START  (s_ls),
    .FRAME_START (s_fs),
    .PIX_X       (s_px),
    .PIX_Y       (s_py)
  );

  sb_ent_t sb_q[$];
  int      n_chk   = 0;
  int      n_fail  = 0;
  logic    running = 1'b0;

  // Reference: the k-th pixel enable since reset presents raster pixel k.
  function automatic exp_t model(input int n, input int hsw, input int hbp,
                                 input int hact, input int hfp, input int vsw,
                                 input int vbp, input int vact, input int vfp);
    exp_t e;
    int   ht, vt, h, v;
    logic hde, vde;
    ht   = hsw + hbp + hact + hfp;
    vt   = vsw + vbp + vact + vfp;
    h    = n % ht;
    v    = (n / ht) % vt;
    hde  = (h >= hsw + hbp) && (h < hsw + hbp + hact);
    vde  = (v >= vsw + vbp) && (v < vsw + vbp + vact);
    e    = EXP_RST;
    e.hs = !(h < hsw);
    e.vs = !(v < vsw);
    e.de = hde && vde;
    e.hc = 10'(h);
    e.vc = 10'(v);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
`ifdef LCD_TIMING_PIXCOORD_EN
    if (hde && vde) begin
      e.px = 10'(h - (hsw + hbp));
      e.py = 10'(v - (vsw + vbp));
    end
`endif
    return e;
  endfunction

  // Driver-owned model state.
  int   m_n = 0;
  exp_t m_d = EXP_RST;
  exp_t m_s = EXP_RST;

  task automatic step(input logic r, input logic c);
    sb_ent_t e;
    @(negedge clk);
    rst = r;
    ce  = c;
    if (r) begin
      m_d = EXP_RST;
      m_s = EXP_RST;
      m_n = 0;
    end else if (c) begin
      m_d = model(m_n, 41, 2, 480, 2, 10, 2, 272, 2);
      m_s = model(m_n, 3, 2, 8, 2, 2, 1, 4, 1);
      m_n++;
    end else begin
      m_d.ls = 1'b0;
      m_d.fs = 1'b0;
      m_s.ls = 1'b0;
      m_s.fs = 1'b0;
    end
    e.rst = r;
    e.ce  = c;
    e.d   = m_d;
    e.s   = m_s;
    sb_q.push_back(e);
    running = 1'b1;
  endtask

  task automatic chk_vec(input string name, input exp_t act, input exp_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (hs,vs,de,hc,vc,ls,fs,px,py)",
               name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor-owned measurement state (default-timing instance unless noted).
  int hs_run   = 0;
  int de_run   = 0;
  int ls_cnt   = 0;
  int ls_seen  = 0;
  int vs_lines = 0;
  int sfs_cnt  = 0;
  int sfs_seen = 0;

  // Pop one expectation per clock and compare, then measure run lengths.
  always @(posedge clk) begin
    sb_ent_t ent;
    exp_t    act_d, act_s;
    #1;
    if (sb_q.size() == 0) begin
      if (running) begin
        chk_int("scoreboard_underflow", 0, 1);
      end
    end else begin
      ent   = sb_q.pop_front();
      act_d = {d_hs, d_vs, d_de, d_hc, d_vc, d_ls, d_fs, d_px, d_py};
      act_s = {s_hs, s_vs, s_de, s_hc, s_vc, s_ls, s_fs, s_px, s_py};
      chk_vec("dflt_outputs", act_d, ent.d);
      chk_vec("small_outputs", act_s, ent.s);
      if (ent.rst) begin
        hs_run   = 0;
        de_run   = 0;
        ls_cnt   = 0;
        ls_seen  = 0;
        vs_lines = 0;
        sfs_cnt  = 0;
        sfs_seen = 0;
      end else if (ent.ce) begin
        if (!d_hs) begin
          hs_run++;
        end else if (hs_run != 0) begin
          chk_int("hsync_low_width", hs_run, 41);
          hs_run = 0;
        end
        if (d_de) begin
          if (de_run == 0) chk_int("de_first_hcount", int'(d_hc), 43);
          de_run++;
        end else if (de_run != 0) begin
          chk_int("de_width", de_run, 480);
          de_run = 0;
        end
        ls_cnt++;
        if (d_ls) begin
          if (ls_seen != 0) chk_int("line_start_period", ls_cnt, 525);
          ls_seen = 1;
          ls_cnt  = 0;
          if (!d_vs) begin
            vs_lines++;
          end else if (vs_lines != 0) begin
            chk_int("vsync_low_lines", vs_lines, 10);
            vs_lines = 0;
          end
        end
        sfs_cnt++;
        if (s_fs) begin
          if (sfs_seen != 0) chk_int("small_frame_period", sfs_cnt, 120);
          sfs_seen = 1;
          sfs_cnt  = 0;
        end
      end
    end
  end

  initial begin
    // Reset held with the enable active.
    repeat (5) step(1'b1, 1'b1);
    // Free-run past line 12 up to the pixel (300,100).
    while (m_n != 100 * 525 + 301) step(1'b0, 1'b1);
    // Mid-frame reset, then a few idle cycles and a restart.
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (200) step(1'b0, 1'b1);
    // Enable toggling every cycle.
    for (int i = 0; i < 600; i++) step(1'b0, (i % 2) == 0);
    // Irregular enable with a reset taken while the enable is low.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) step(1'b1, 1'b0);
      else          step(1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (50) step(1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_lcd_timing_gen
`default_nettype wire
